// File: rtl/issue_stage_pkg.sv
// Shared opcode map, instruction decode table and state type for the issue stage.
// Latency: n/a (types, constants and a pure decode function).
// Backpressure: n/a.
package issue_stage_pkg;

    localparam int DATA_W  = 16;
    localparam int RADDR_W = 3;
    localparam int OP_W    = 5;

    localparam logic [OP_W-1:0] OP_NOP   = 5'b00000;
    localparam logic [OP_W-1:0] OP_HALT  = 5'b00001;
    localparam logic [OP_W-1:0] OP_LOAD  = 5'b00010;
    localparam logic [OP_W-1:0] OP_STORE = 5'b00011;
    localparam logic [OP_W-1:0] OP_SLL   = 5'b00100;
    localparam logic [OP_W-1:0] OP_MOV   = 5'b00101;
    localparam logic [OP_W-1:0] OP_SRL   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SRA   = 5'b00111;
    localparam logic [OP_W-1:0] OP_ADD   = 5'b01000;
    localparam logic [OP_W-1:0] OP_ADDI  = 5'b01001;
    localparam logic [OP_W-1:0] OP_SUB   = 5'b01010;
    localparam logic [OP_W-1:0] OP_SUBI  = 5'b01011;
    localparam logic [OP_W-1:0] OP_CMP   = 5'b01100;
    localparam logic [OP_W-1:0] OP_AND   = 5'b01101;
    localparam logic [OP_W-1:0] OP_OR    = 5'b01110;
    localparam logic [OP_W-1:0] OP_XOR   = 5'b01111;
    localparam logic [OP_W-1:0] OP_LDIH  = 5'b10000;
    localparam logic [OP_W-1:0] OP_ADDC  = 5'b10001;
    localparam logic [OP_W-1:0] OP_SUBC  = 5'b10010;
    localparam logic [OP_W-1:0] OP_ADDRI = 5'b10011;
    localparam logic [OP_W-1:0] OP_SUBRI = 5'b10100;
    localparam logic [OP_W-1:0] OP_NOT   = 5'b10101;
    localparam logic [OP_W-1:0] OP_MOVR  = 5'b10110;
    localparam logic [OP_W-1:0] OP_ROR   = 5'b10111;
    localparam logic [OP_W-1:0] OP_JUMP  = 5'b11000;
    localparam logic [OP_W-1:0] OP_JMPR  = 5'b11001;
    localparam logic [OP_W-1:0] OP_BZ    = 5'b11010;
    localparam logic [OP_W-1:0] OP_BNZ   = 5'b11011;
    localparam logic [OP_W-1:0] OP_BN    = 5'b11100;
    localparam logic [OP_W-1:0] OP_BNN   = 5'b11101;
    localparam logic [OP_W-1:0] OP_BC    = 5'b11110;
    localparam logic [OP_W-1:0] OP_BNC   = 5'b11111;

    typedef enum logic {ST_RUN, ST_HALTED} state_e;

    // Source of operand 2.
    typedef enum logic [2:0] {
        O2_ZERO, O2_RB, O2_VAL3, O2_IMM8, O2_IMM8_HI
    } op2_sel_e;

    // Decoded view of one instruction. Port A feeds oper1, port B feeds
    // oper2 (register forms) or store_data (STORE).
    typedef struct packed {
        logic [OP_W-1:0] op;
        logic            use_a;
        logic            a_is_r1;
        logic            use_b;
        logic            b_is_r1;
        op2_sel_e        op2_sel;
        logic            is_store;
        logic            wen;
    } dec_t;

    function automatic dec_t decode(input logic [OP_W-1:0] op);
        dec_t d;
        d = '{op: OP_NOP, op2_sel: O2_ZERO, default: '0};
        case (op)
            OP_ADD, OP_SUB, OP_ADDC, OP_SUBC, OP_AND, OP_OR, OP_XOR, OP_CMP: begin
                d.op = op; d.use_a = 1'b1; d.use_b = 1'b1; d.op2_sel = O2_RB;
                d.wen = (op != OP_CMP);
            end
            OP_NOT, OP_MOVR: begin
                d.op = op; d.use_a = 1'b1; d.wen = 1'b1;
            end
            OP_SLL, OP_SRL, OP_SRA, OP_ROR, OP_LOAD: begin
                d.op = op; d.use_a = 1'b1; d.op2_sel = O2_VAL3; d.wen = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_ADDRI, OP_SUBRI: begin
                d.op = op; d.use_a = 1'b1; d.a_is_r1 = 1'b1; d.op2_sel = O2_IMM8; d.wen = 1'b1;
            end
            OP_LDIH: begin
                d.op = op; d.use_a = 1'b1; d.a_is_r1 = 1'b1; d.op2_sel = O2_IMM8_HI; d.wen = 1'b1;
            end
            OP_MOV: begin
                d.op = op; d.op2_sel = O2_IMM8; d.wen = 1'b1;
            end
            OP_STORE: begin
                d.op = op; d.use_a = 1'b1; d.use_b = 1'b1; d.b_is_r1 = 1'b1;
                d.op2_sel = O2_VAL3; d.is_store = 1'b1;
            end
            OP_JUMP: begin
                d.op = op; d.op2_sel = O2_IMM8;
            end
            OP_JMPR, OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: begin
                d.op = op; d.use_a = 1'b1; d.a_is_r1 = 1'b1; d.op2_sel = O2_IMM8;
            end
            OP_HALT: d.op = OP_HALT;
            default: d.op = OP_NOP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/issue_stage_operand_fwd.sv
// Per-operand bypass mux: EX > MEM > WB > register file, matched on read address.
// Latency: purely combinational.
// Backpressure: none; ports raddr_i, ex/mem/wb wen/waddr/wdata, rf_rdata_i in, data_o out.
module issue_stage_operand_fwd
    import issue_stage_pkg::*;
(
    input  logic [RADDR_W-1:0] raddr_i,
    input  logic               ex_wen_i,
    input  logic [RADDR_W-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0]  ex_wdata_i,
    input  logic               mem_wen_i,
    input  logic [RADDR_W-1:0] mem_waddr_i,
    input  logic [DATA_W-1:0]  mem_wdata_i,
    input  logic               wb_wen_i,
    input  logic [RADDR_W-1:0] wb_waddr_i,
    input  logic [DATA_W-1:0]  wb_wdata_i,
    input  logic [DATA_W-1:0]  rf_rdata_i,
    output logic [DATA_W-1:0]  data_o
);

    always_comb begin
        data_o = rf_rdata_i;
        if (ex_wen_i && (ex_waddr_i == raddr_i)) begin
            data_o = ex_wdata_i;
        end else if (mem_wen_i && (mem_waddr_i == raddr_i)) begin
            data_o = mem_wdata_i;
        end else if (wb_wen_i && (wb_waddr_i == raddr_i)) begin
            data_o = wb_wdata_i;
        end
    end

endmodule

// File: rtl/issue_stage.sv
// Decode/issue stage: decodes fetch instr, reads RF with EX/MEM/WB bypass, registers ALU operands.
// Latency: 1 cycle from acceptance to oper_code/oper1/oper2/store_data/dest/reg_wen.
// Backpressure: instr_ready drops for a load-use stall and while halted; flush forces ready and a bubble.
module issue_stage
    import issue_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [15:0]        instr,
    output logic               instr_ready,
    output logic [RADDR_W-1:0] rf_raddr_a,
    output logic [RADDR_W-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0]  rf_rdata_a,
    input  logic [DATA_W-1:0]  rf_rdata_b,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               mem_wen,
    input  logic [RADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0]  mem_wdata,
    input  logic               wb_wen,
    input  logic [RADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0]  wb_wdata,
    input  logic               flush,
    input  logic               restart,
    output logic [OP_W-1:0]    oper_code,
    output logic [DATA_W-1:0]  oper1,
    output logic [DATA_W-1:0]  oper2,
    output logic [DATA_W-1:0]  store_data,
    output logic [RADDR_W-1:0] dest,
    output logic               reg_wen,
    output logic               halted
);

    state_e               state_q, state_d;
    logic [OP_W-1:0]      op_q, op_d;
    logic [DATA_W-1:0]    oper1_q, oper1_d, oper2_q, oper2_d, sdata_q, sdata_d;
    logic [RADDR_W-1:0]   dest_q, dest_d;
    logic                 wen_q, wen_d;

    dec_t                 dec;
    logic [RADDR_W-1:0]   f_r1, f_r2, f_r3;
    logic [3:0]           f_val3;
    logic [7:0]           f_imm8;
    logic [DATA_W-1:0]    fwd_a, fwd_b;
    logic                 ex_fwd_en, hazard, issue;

    assign dec    = decode(instr[15:11]);
    assign f_r1   = instr[10:8];
    assign f_r2   = instr[6:4];
    assign f_r3   = instr[2:0];
    assign f_val3 = instr[3:0];
    assign f_imm8 = instr[7:0];

    assign rf_raddr_a = dec.a_is_r1 ? f_r1 : f_r2;
    assign rf_raddr_b = dec.b_is_r1 ? f_r1 : f_r3;

    // A LOAD in EX has no result yet, so it must not bypass; the stall covers it.
    assign ex_fwd_en = wen_q && (op_q != OP_LOAD);

    assign hazard = instr_valid && (op_q == OP_LOAD) &&
                    ((dec.use_a && (dest_q == rf_raddr_a)) ||
                     (dec.use_b && (dest_q == rf_raddr_b)));

    issue_stage_operand_fwd u_fwd_a (
        .raddr_i     (rf_raddr_a),
        .ex_wen_i    (ex_fwd_en),
        .ex_waddr_i  (dest_q),
        .ex_wdata_i  (alu_result),
        .mem_wen_i   (mem_wen),
        .mem_waddr_i (mem_waddr),
        .mem_wdata_i (mem_wdata),
        .wb_wen_i    (wb_wen),
        .wb_waddr_i  (wb_waddr),
        .wb_wdata_i  (wb_wdata),
        .rf_rdata_i  (rf_rdata_a),
        .data_o      (fwd_a)
    );

    issue_stage_operand_fwd u_fwd_b (
        .raddr_i     (rf_raddr_b),
        .ex_wen_i    (ex_fwd_en),
        .ex_waddr_i  (dest_q),
        .ex_wdata_i  (alu_result),
        .mem_wen_i   (mem_wen),
        .mem_waddr_i (mem_waddr),
        .mem_wdata_i (mem_wdata),
        .wb_wen_i    (wb_wen),
        .wb_waddr_i  (wb_waddr),
        .wb_wdata_i  (wb_wdata),
        .rf_rdata_i  (rf_rdata_b),
        .data_o      (fwd_b)
    );

    // Control: flush dominates everything (including HALTED and a stall).
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        issue       = 1'b0;
        if (flush) begin
            instr_ready = 1'b1;
            state_d     = ST_RUN;
        end else if (state_q == ST_HALTED) begin
            if (restart) state_d = ST_RUN;
        end else begin
            instr_ready = !hazard;
            if (instr_valid && !hazard) begin
                issue = 1'b1;
                if (dec.op == OP_HALT) state_d = ST_HALTED;
            end
        end
    end

    // Next output registers; anything not issued becomes a NOP bubble.
    always_comb begin
        op_d    = OP_NOP;
        oper1_d = '0;
        oper2_d = '0;
        sdata_d = '0;
        dest_d  = '0;
        wen_d   = 1'b0;
        if (issue) begin
            op_d    = dec.op;
            oper1_d = dec.use_a ? fwd_a : '0;
            sdata_d = dec.is_store ? fwd_b : '0;
            dest_d  = dec.wen ? f_r1 : '0;
            wen_d   = dec.wen;
            case (dec.op2_sel)
                O2_RB:      oper2_d = fwd_b;
                O2_VAL3:    oper2_d = {12'h000, f_val3};
                O2_IMM8:    oper2_d = {8'h00, f_imm8};
                O2_IMM8_HI: oper2_d = {f_imm8, 8'h00};
                default:    oper2_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            op_q    <= OP_NOP;
            oper1_q <= '0;
            oper2_q <= '0;
            sdata_q <= '0;
            dest_q  <= '0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            oper1_q <= oper1_d;
            oper2_q <= oper2_d;
            sdata_q <= sdata_d;
            dest_q  <= dest_d;
            wen_q   <= wen_d;
        end
    end

    assign oper_code  = op_q;
    assign oper1      = oper1_q;
    assign oper2      = oper2_q;
    assign store_data = sdata_q;
    assign dest       = dest_q;
    assign reg_wen    = wen_q;
    assign halted     = (state_q == ST_HALTED);

endmodule
